// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one cache-bus master port among NUM_REQ requesters.
// Latency: grant registered (request at edge t forwarded from cycle t+1); req/resp pass-through is combinational.
// Backpressure: a grant is held for the whole transaction; other requesters wait, oresp.ready paces beats.

package cbus_pkg;

    localparam logic [3:0] MLEN1  = 4'd0;
    localparam logic [3:0] MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned SEL_W  = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_REQ],
    output cbus_resp_t       iresps [NUM_REQ],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [SEL_W-1:0] grant_idx,
    output logic             proto_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] sel;
    logic [8:0]       beat_cnt;

    logic             scan_hit;
    logic [SEL_W-1:0] scan_idx;
    logic [SEL_W-1:0] sel_nxt;
    logic             xfer_end;

    // Pick the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int unsigned      pos;
            logic [SEL_W-1:0] cand;
            pos = int'(rr_ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = SEL_W'(pos);
            if (!scan_hit && ireqs[cand].valid) begin
                scan_hit = 1'b1;
                scan_idx = cand;
            end
        end
    end

    // Next round-robin start point: the requester after the one just served.
    always_comb begin
        sel_nxt = (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end

    assign xfer_end = oresp.ready && oresp.last;

    // Grant FSM, beat counter and sticky protocol-error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            sel       <= '0;
            beat_cnt  <= '0;
            proto_err <= 1'b0;
        end else if (state == S_IDLE) begin
            // A response with nobody granted means the memory side is out of step.
            if (oresp.ready || oresp.last) begin
                proto_err <= 1'b1;
            end
            if (scan_hit) begin
                sel      <= scan_idx;
                beat_cnt <= '0;
                state    <= S_BUSY;
            end
        end else begin
            if (oresp.ready && (beat_cnt != 9'd511)) begin
                beat_cnt <= beat_cnt + 9'd1;
            end
            if (!ireqs[sel].valid) begin
                // Requester abandoned the transaction: release without flagging.
                state  <= S_IDLE;
                rr_ptr <= sel_nxt;
            end else if (xfer_end) begin
                state  <= S_IDLE;
                rr_ptr <= sel_nxt;
                // This beat is beat_cnt+1; expected len+1, so compare beat_cnt to len.
                if (beat_cnt != {5'd0, ireqs[sel].len}) begin
                    proto_err <= 1'b1;
                end
            end
        end
    end

    // Forward the granted request and route the response back only while BUSY.
    always_comb begin
        oreq = '0;
        if (state == S_BUSY) begin
            oreq = ireqs[sel];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            iresps[i] = '0;
            if ((state == S_BUSY) && (sel == SEL_W'(i))) begin
                iresps[i] = oresp;
            end
        end
    end

    assign busy      = (state == S_BUSY);
    assign grant_idx = sel;

endmodule
